// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART (STAT/RX/TX words) with TX and RX byte FIFOs.
// Latency: bus response registered one cycle after the request; an idle TX store starts its frame two cycles later.
// Backpressure: none on the bus; TX stores into a full FIFO are dropped, RX bytes arriving at a full FIFO are dropped and flag OVR.
module uart_mmio #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [3:0]  req_wmask,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus decode
  logic stat_rd, rx_rd, tx_wr;
  assign stat_rd = req_valid && !req_write && (req_addr == 2'd0);
  assign rx_rd   = req_valid && !req_write && (req_addr == 2'd1);
  assign tx_wr   = req_valid &&  req_write && (req_addr == 2'd2) && req_wmask[0];

  // Only the low byte lane of a store carries data into the UART.
  logic unused_bus;
  assign unused_bus = ^{req_wmask[3:1], req_wdata[31:8]};

  // ---------------- TX FIFO ----------------
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp;
  logic        tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);

  state_t          tx_state;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_sh;

  // The shifter takes a byte when idle, or straight out of the stop bit so frames run back to back.
  assign tx_pop  = !tx_empty && ((tx_state == S_IDLE) ||
                                 (tx_state == S_STOP && tx_cnt == BIT_LAST));
  // A full FIFO still accepts a store when the shifter pops in the same cycle.
  assign tx_push = tx_wr && (!tx_full || tx_pop);

  // TX FIFO pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  // TX FIFO storage write
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= req_wdata[7:0];
  end

  // Transmitter FSM; uart_txd is registered from the current state, one cycle behind it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      uart_txd <= 1'b1;
    end else begin
      case (tx_state)
        S_START: uart_txd <= 1'b0;
        S_DATA:  uart_txd <= tx_sh[0];
        default: uart_txd <= 1'b1;
      endcase
      case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_sh    <= tx_mem[tx_rp[AW-1:0]];
            tx_cnt   <= '0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            tx_sh  <= {1'b0, tx_sh[7:1]};
            if (tx_bit == 3'd7) tx_state <= S_STOP;
            else                tx_bit   <= tx_bit + 3'd1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_sh    <= tx_mem[tx_rp[AW-1:0]];
              tx_state <= S_START;
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic [1:0] rx_sync;
  logic       rxs;

  // Two-flop synchronizer for the asynchronous serial input, idling high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_sync <= 2'b11;
    else      rx_sync <= {rx_sync[0], uart_rxd};
  end
  assign rxs = rx_sync[1];

  state_t        rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;

  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wp, rx_rp;
  logic        rx_empty, rx_full, rx_done, rx_push_req, rx_push, rx_pop;
  logic        ovr_evt, ferr_evt;

  assign rx_empty    = (rx_wp == rx_rp);
  assign rx_full     = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rx_done     = (rx_state == S_STOP) && (rx_cnt == BIT_LAST);
  assign rx_push_req = rx_done && rxs;
  assign ferr_evt    = rx_done && !rxs;
  assign rx_pop      = rx_rd && !rx_empty;
  // A CPU pop in the stop-sample cycle frees the slot, so the byte lands without overrun.
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign ovr_evt     = rx_push_req && !rx_push;

  // Receiver FSM: half-bit start check, then one sample per bit period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (!rxs) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxs ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rxs, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // RX FIFO pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  // RX FIFO storage write
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
  end

  // Sticky error flags: a STAT read clears them, a same-cycle event keeps its flag set
  logic ovr, ferr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= (ovr  && !stat_rd) || ovr_evt;
      ferr <= (ferr && !stat_rd) || ferr_evt;
    end
  end

  logic [31:0] stat_word;
  assign stat_word = {26'b0, ferr, ovr, tx_full, (tx_empty && tx_state == S_IDLE), rx_full, rx_empty};

  // Registered bus response: one strobe per request, data only for STAT and non-empty RX loads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= req_valid;
      resp_rdata <= '0;
      if (stat_rd)     resp_rdata <= stat_word;
      else if (rx_pop) resp_rdata <= {24'b0, rx_mem[rx_rp[AW-1:0]]};
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed bench for uart_mmio with a bus-response scoreboard and a serial TX frame monitor.
// Latency: expects bus responses one cycle after each request and TX start two cycles after an idle store.
// Backpressure: exercises TX FIFO overflow, RX overrun, framing error, glitch rejection and full-FIFO pop/push collision.
module tb_uart_mmio;
  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_addr  = 2'd0;
  logic [3:0]  req_wmask = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        uart_txd;
  logic        uart_rxd;
  logic        rxd_drv = 1'b1;
  logic        loop    = 1'b0;

  assign uart_rxd = loop ? uart_txd : rxd_drv;

  uart_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wmask  (req_wmask),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .uart_txd   (uart_txd),
    .uart_rxd   (uart_rxd)
  );

  typedef struct {
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t       bus_q[$];
  logic [7:0] tx_exp[$];
  int         start_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  int         tx_falls = 0;
  logic       txd_prev = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  // Bus response monitor: pops one expectation per response strobe
  always @(negedge clk) begin
    if (resp_valid) begin
      if (bus_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL bus_unexpected: got response 0x%08h, none expected", resp_rdata);
      end else begin
        exp_t e;
        e = bus_q.pop_front();
        chk(e.tag, resp_rdata, e.val);
      end
    end
  end

  // Falling-edge counter on the serial output
  always @(negedge clk) begin
    if (txd_prev && !uart_txd) tx_falls++;
    txd_prev = uart_txd;
  end

  // TX frame monitor: captures every cycle of a frame, checks bit timing and data
  initial begin
    logic [FRAME-1:0] smp;
    logic [7:0]       got;
    logic [7:0]       want;
    int               bad;
    bit               aborted;
    forever begin
      @(negedge clk);
      if (rst && !uart_txd) begin
        start_q.push_back(cyc);
        aborted = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
          if (i != 0) @(negedge clk);
          if (!rst) begin
            aborted = 1'b1;
            break;
          end
          smp[i] = uart_txd;
        end
        if (!aborted) begin
          bad = 0;
          for (int i = 0; i < FRAME; i++)
            if (smp[i] != smp[(i / CPB) * CPB]) bad++;
          if (smp[0] != 1'b0) bad++;
          if (smp[FRAME-CPB] != 1'b1) bad++;
          for (int k = 0; k < 8; k++) got[k] = smp[(k + 1) * CPB];
          n_cmp++;
          if (tx_exp.size() == 0) begin
            n_err++;
            $display("FAIL tx_unexpected_frame: got byte 0x%02h, none expected", got);
          end else begin
            want = tx_exp.pop_front();
            if (got !== want || bad != 0) begin
              n_err++;
              $display("FAIL tx_frame: got 0x%02h (%0d bad samples) want 0x%02h", got, bad, want);
            end
          end
        end
      end
    end
  end

  task automatic bus(input logic wr, input logic [1:0] a, input logic [3:0] m,
                     input logic [31:0] d, input logic [31:0] exp, input string tag);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wmask = m;
    req_wdata = d;
    e.val = exp;
    e.tag = tag;
    bus_q.push_back(e);
    @(posedge clk);
    #1;
    last_cyc  = cyc;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 2'd0;
    req_wmask = 4'd0;
    req_wdata = 32'd0;
  endtask

  task automatic stat(input logic [31:0] exp, input string tag);
    bus(1'b0, 2'd0, 4'h0, 32'd0, exp, tag);
  endtask

  task automatic rx_rd(input logic [31:0] exp, input string tag);
    bus(1'b0, 2'd1, 4'h0, 32'd0, exp, tag);
  endtask

  task automatic tx_wr(input logic [7:0] b, input string tag);
    bus(1'b1, 2'd2, 4'hF, {24'hDEADBE, b}, 32'd0, tag);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd_drv = stop;
    repeat (CPB) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_tx(input int budget);
    for (int i = 0; i < budget && tx_exp.size() != 0; i++) @(negedge clk);
    chk("tx_drain_timeout", tx_exp.size(), 0);
  endtask

  task automatic summary;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  initial begin
    #(60000 * 10);
    n_err++;
    $display("FAIL watchdog: simulation exceeded its time limit");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tb_bytes [10];
    logic [7:0] ov [9];
    logic [7:0] col [9];
    int t_store, s0, f0, gaps;

    tb_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    ov       = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'hFF, 8'h00, 8'h7E, 8'hC3, 8'h99};
    col      = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h5A};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_txd", uart_txd, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    stat(32'h5, "stat_after_reset");

    // Ignored stores and zero-returning loads
    bus(1'b1, 2'd0, 4'hF, 32'hFFFF_FFFF, 32'd0, "stat_store_resp");
    bus(1'b0, 2'd2, 4'h0, 32'd0,         32'd0, "tx_load");
    bus(1'b0, 2'd3, 4'h0, 32'd0,         32'd0, "rsvd_load");
    bus(1'b1, 2'd3, 4'hF, 32'h0000_0041, 32'd0, "rsvd_store_resp");
    bus(1'b1, 2'd1, 4'hF, 32'h0000_0041, 32'd0, "rx_store_resp");
    bus(1'b1, 2'd2, 4'hE, 32'h0000_0041, 32'd0, "tx_store_nomask_resp");
    stat(32'h5, "stat_after_ignored_ops");

    // Reset in the middle of a TX frame
    tx_wr(8'h33, "tx_store_before_reset");
    repeat (40) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("txd_during_reset", uart_txd, 1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    f0 = tx_falls;
    repeat (300) @(negedge clk);
    chk("no_tx_after_reset", tx_falls, f0);
    chk("txd_idle_after_reset", uart_txd, 1);
    stat(32'h5, "stat_after_midframe_reset");

    // Single TX byte: timing, latency, TXEMPTY during and after
    start_q.delete();
    tx_exp.push_back(8'hA5);
    tx_wr(8'hA5, "tx_store_a5");
    t_store = last_cyc;
    repeat (20) @(negedge clk);
    stat(32'h1, "stat_tx_busy");
    wait_tx(FRAME + 100);
    s0 = (start_q.size() > 0) ? start_q[0] : -1000;
    chk("tx_start_latency", s0 - t_store, 2);
    repeat (5) @(negedge clk);
    stat(32'h5, "stat_tx_done");

    // TX FIFO overflow: 10 back-to-back stores, 9 frames
    start_q.delete();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) tx_exp.push_back(tb_bytes[i]);
      tx_wr(tb_bytes[i], "tx_store_burst");
    end
    stat(32'h9, "stat_tx_full");
    wait_tx(9 * FRAME + 200);
    chk("tx_frame_count", start_q.size(), 9);
    gaps = 0;
    for (int i = 1; i < start_q.size(); i++)
      if (start_q[i] - start_q[i-1] != FRAME) gaps++;
    chk("tx_contiguous_gaps", gaps, 0);
    repeat (FRAME + 40) @(negedge clk);
    chk("tx_no_tenth_frame", start_q.size(), 9);
    stat(32'h5, "stat_after_burst");

    // Loopback
    loop = 1'b1;
    tx_exp.push_back(8'h3C);
    tx_wr(8'h3C, "tx_store_3c");
    repeat (185) @(negedge clk);
    stat(32'h4, "stat_rx_loop");
    rx_rd(32'h3C, "rx_loop_byte");
    rx_rd(32'h0, "rx_read_empty");
    stat(32'h5, "stat_after_loop");
    loop = 1'b0;
    wait_tx(50);

    // Overrun: 9 frames, first 8 kept
    for (int i = 0; i < 9; i++) send_rx(ov[i], 1'b1);
    stat(32'h16, "stat_ovr");
    stat(32'h06, "stat_ovr_cleared");
    for (int i = 0; i < 8; i++) rx_rd({24'd0, ov[i]}, "rx_ovr_byte");
    stat(32'h5, "stat_after_ovr");

    // Framing error
    send_rx(8'h42, 1'b0);
    repeat (20) @(negedge clk);
    stat(32'h25, "stat_ferr");
    stat(32'h05, "stat_ferr_cleared");
    rx_rd(32'h0, "rx_after_ferr");

    // Glitch rejection
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (3) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    stat(32'h5, "stat_glitch");

    // Pop of a full RX FIFO on the same edge as the stop-bit push
    for (int i = 0; i < 8; i++) send_rx(col[i], 1'b1);
    stat(32'h6, "stat_rx_full");
    fork
      send_rx(col[8], 1'b1);
      begin
        repeat (154) @(negedge clk);
        rx_rd({24'd0, col[0]}, "rx_collision_pop");
      end
    join
    stat(32'h6, "stat_collision");
    for (int i = 1; i < 9; i++) rx_rd({24'd0, col[i]}, "rx_collision_byte");
    stat(32'h5, "stat_final");

    repeat (5) @(negedge clk);
    chk("bus_q_drained", bus_q.size(), 0);
    chk("tx_exp_drained", tx_exp.size(), 0);
    summary();
    $finish;
  end

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Synthesizable memory-mapped UART peripheral occupying the 16-byte window at 0x30010000 (STAT, RX, TX). It answers CPU load/store requests from the data-side bus and drives and receives an 8N1 serial line through TX and RX byte FIFOs. Status bit positions match the simulation UART model, so software that runs against the model runs unchanged on hardware.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit, even, ≥4.
- FIFO_DEPTH, 8: entries per FIFO, power of two, ≥2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- req_valid  input  1  bus request this cycle; always accepted, no backpressure.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  2  word offset, addr[3:2] (0 = STAT, 1 = RX, 2 = TX, 3 = reserved).
- req_wmask  input  4  store byte enables.
- req_wdata  input  32  store data.
- resp_valid  output  1  response strobe, one cycle.
- resp_rdata  output  32  load data; 0 for stores.
- uart_txd  output  1  serial out; idle high.
- uart_rxd  input  1  serial in; asynchronous to clk.

## Operation
- **STAT read (offset 0)**:
  - Returns {26'b0, FERR, OVR, TXFULL, TXEMPTY, RXFULL, RXEMPTY} (bits 5..0).
  - TXEMPTY = TX FIFO empty AND TX FSM in IDLE.
  - OVR and FERR are sticky. A STAT read clears both in the response cycle. A new error event in that same cycle wins and leaves its flag set.
- **STAT write**: ignored.
- **RX read (offset 1)**: pops one byte and returns it zero-extended. If the FIFO is empty, returns 0 and does not pop.
- **TX write (offset 2)**: with wmask[0]=1, pushes wdata[7:0]. If the FIFO is full, the byte is silently dropped. With wmask[0]=0, ignored.
- **TX and RX loads**: a load of TX returns 0. Stores to RX are ignored.
- **Offset 3**: loads return 0; stores are ignored.
- **Transmitter FSM** (IDLE → START → DATA → STOP → IDLE):
  - IDLE: uart_txd=1. If the FIFO is non-empty, pop into the shifter and go to START.
  - START: drive 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, counted by a 3-bit bit counter.
  - STOP: drive 1 for CLKS_PER_BIT cycles. Then return to IDLE and pop the next byte in the same cycle if one is present. Back-to-back frames have no extra idle bit.
- **Receiver**: uart_rxd passes through a 2-flop synchronizer (reset to 1). FSM IDLE → START → DATA → STOP:
  - IDLE: a synchronized 0 moves to START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If the sample is 1, treat it as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sample 1: push the byte. If the FIFO is full, drop the byte and set OVR.
    - Sample 0: discard the byte and set FERR.
    - Either way, return to IDLE.
- **FIFO full-boundary rule**: a push and a pop in the same cycle on a full FIFO both succeed and the count is unchanged. On an empty FIFO, a simultaneous push and pop means the pop finds nothing. The pushed byte is retained.
- **FIFO storage**: circular buffers with log2(FIFO_DEPTH)+1-bit pointers. Full and empty are derived from the pointer MSB difference.
- **Reset**: reset mid-frame aborts both FSMs to IDLE immediately (asynchronously). Any partial frame is lost.

## Timing
- **Reset values**:
  - resp_valid=0, resp_rdata=0, uart_txd=1.
  - Both FIFOs empty, OVR=FERR=0.
  - A STAT read after reset returns 0x00000005.
- **Bus response**:
  - A request sampled at edge N produces resp_valid=1 with data during cycle N+1 (registered).
  - Every request gets exactly one response, including stores and reserved offsets.
  - Consecutive requests on every cycle are legal.
- **Pop and push visibility**:
  - An RX pop at edge N is visible in a STAT read sampled at edge N+1.
  - A TX push at edge N is visible in STAT at edge N+1.
- **TX latency**: with the transmitter idle and the FIFO empty, a TX store sampled at edge N makes uart_txd fall after edge N+2. The frame occupies exactly 10·CLKS_PER_BIT cycles.
- **RX latency**: a received byte is in the FIFO (RXEMPTY=0) at the edge after the stop-bit sample. That sample falls about 9.5·CLKS_PER_BIT + 2 cycles after the start edge on uart_rxd.

## Test plan
- **Reset state**: assert rst=0 mid-TX frame, release, read STAT → 0x5, uart_txd=1, no further serial transitions.
- **TX single byte**: with CLKS_PER_BIT=16, store 0xA5 to TX → line reads 0, 1,0,1,0,0,1,0,1, 1, each bit 16 cycles. TXEMPTY reads 0 during the frame and 1 after it.
- **TX full**: store 10 bytes back-to-back with FIFO_DEPTH=8 → 9 bytes transmitted contiguously (8 in the FIFO plus 1 popped into the shifter), the 10th dropped. TXFULL is observed.
- **RX loopback**: tie txd to rxd, send 0x3C → RXEMPTY drops, RX read returns 0x0000003C, a second RX read returns 0 and STAT shows 0x5.
- **RX overrun and framing errors**:
  - Inject 9 frames without reading → RXFULL=1 and OVR=1; the first 8 bytes are read back in order. A STAT read clears OVR.
  - Inject a frame with stop bit 0 → FERR=1 and no push.
- **Glitch and collision**:
  - A 3-cycle low pulse on rxd → no byte and no flags.
  - An RX pop on a full FIFO in the same cycle as a stop-bit push → push accepted, count stays 8, OVR stays 0.
